// File: rtl/triangle_assembler.sv
// Collects a stream of vertices into triangles, optionally discarding degenerate ones,
// and presents each triangle with the flat color of its last (provoking) vertex.
module triangle_assembler #(
   parameter bit CULL_DEGENERATE = 1'b1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   valid_in,
   output logic                   ready_out,
   input  logic [3:0][31:0]       vertex_in,
   input  logic [11:0]            color_in,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [2:0][3:0][31:0]  triangle_out,
   output logic [11:0]            color_out,
   output logic [15:0]            tri_count_out,
   output logic [15:0]            culled_count_out
);

   logic [1:0]       slot;
   logic [3:0][31:0] v0;
   logic [3:0][31:0] v1;
   logic [15:0]      tri_count;
   logic [15:0]      culled_count;

   logic accept;
   logic out_xfer;
   logic closing;
   logic degenerate;
   logic load;
   logic cull;

   function automatic logic same_xy(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
      return (a[0] == b[0]) && (a[1] == b[1]);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   // A full output register only blocks the vertex that would close a new triangle.
   assign ready_out = (slot != 2'd2) ? 1'b1 : (!valid_out || ready_in);
   assign accept    = valid_in && ready_out;
   assign out_xfer  = valid_out && ready_in;
   assign closing   = accept && (slot == 2'd2);

   always_comb begin
      degenerate = 1'b0;
      if (CULL_DEGENERATE) begin
         degenerate = same_xy(v0, v1) || same_xy(v1, vertex_in) || same_xy(v0, vertex_in);
      end
   end

   assign load = closing && !degenerate;
   assign cull = closing && degenerate;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         slot         <= 2'd0;
         v0           <= '0;
         v1           <= '0;
         valid_out    <= 1'b0;
         triangle_out <= '0;
         color_out    <= '0;
         tri_count    <= '0;
         culled_count <= '0;
      end else begin
         if (accept) begin
            case (slot)
               2'd0:    begin v0 <= vertex_in; slot <= 2'd1; end
               2'd1:    begin v1 <= vertex_in; slot <= 2'd2; end
               default: slot <= 2'd0;
            endcase
         end
         // A load can only happen when the held triangle is absent or leaving this cycle.
         if (load) begin
            triangle_out <= {vertex_in, v1, v0};
            color_out    <= color_in;
            valid_out    <= 1'b1;
            tri_count    <= sat_inc(tri_count);
         end else if (out_xfer) begin
            valid_out <= 1'b0;
         end
         if (cull) begin
            culled_count <= sat_inc(culled_count);
         end
      end
   end

   assign tri_count_out    = tri_count;
   assign culled_count_out = culled_count;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: a scoreboard of expected triangles is filled as
// vertices are accepted and drained by a monitor on every output transfer.
module tb_triangle_assembler;

   typedef struct packed {
      logic [2:0][3:0][31:0] tri_v;
      logic [11:0]           col;
   } tri_t;

   logic                  clk_in = 1'b0;
   logic                  rst_in = 1'b0;
   logic                  valid_in = 1'b0;
   logic                  ready_in = 1'b0;
   logic                  nc_en = 1'b0;
   logic [3:0][31:0]      vertex_in = '0;
   logic [11:0]           color_in = '0;
   logic                  ready_out, valid_out;
   logic [2:0][3:0][31:0] triangle_out;
   logic [11:0]           color_out;
   logic [15:0]           tri_count_out, culled_count_out;

   logic                  nc_valid_in;
   logic                  nc_ready_out, nc_valid_out;
   logic [2:0][3:0][31:0] nc_triangle_out;
   logic [11:0]           nc_color_out;
   logic [15:0]           nc_tri_count_out, nc_culled_count_out;

   triangle_assembler #(.CULL_DEGENERATE(1'b1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
      .vertex_in(vertex_in), .color_in(color_in), .valid_out(valid_out), .ready_in(ready_in),
      .triangle_out(triangle_out), .color_out(color_out),
      .tri_count_out(tri_count_out), .culled_count_out(culled_count_out)
   );

   assign nc_valid_in = valid_in && nc_en;

   triangle_assembler #(.CULL_DEGENERATE(1'b0)) dut_nc (
      .clk_in(clk_in), .rst_in(rst_in), .valid_in(nc_valid_in), .ready_out(nc_ready_out),
      .vertex_in(vertex_in), .color_in(color_in), .valid_out(nc_valid_out), .ready_in(ready_in),
      .triangle_out(nc_triangle_out), .color_out(nc_color_out),
      .tri_count_out(nc_tri_count_out), .culled_count_out(nc_culled_count_out)
   );

   always #5 clk_in = ~clk_in;

   int cycle = 0;
   always @(posedge clk_in) cycle <= cycle + 1;

   tri_t             sb[$];
   int               xfer_t[$];
   int               tests = 0;
   int               fails = 0;
   int               tb_slot = 0;
   logic [3:0][31:0] m_v0 = '0;
   logic [3:0][31:0] m_v1 = '0;
   logic [15:0]      exp_tri = '0;
   logic [15:0]      exp_cull = '0;
   logic [3:0][31:0] last_v;

   function automatic logic m_same(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
      return (a[0] == b[0]) && (a[1] == b[1]);
   endfunction

   function automatic logic [15:0] m_sat(input logic [15:0] value);
      return (value == 16'hFFFF) ? 16'hFFFF : value + 16'd1;
   endfunction

   task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input logic [3:0][31:0] v, input logic [11:0] c);
      tri_t t;
      case (tb_slot)
         0: m_v0 = v;
         1: m_v1 = v;
         default: begin
            if (m_same(m_v0, m_v1) || m_same(m_v1, v) || m_same(m_v0, v)) begin
               exp_cull = m_sat(exp_cull);
            end else begin
               t.tri_v = {v, m_v1, m_v0};
               t.col   = c;
               sb.push_back(t);
               exp_tri = m_sat(exp_tri);
            end
         end
      endcase
      tb_slot = (tb_slot + 1) % 3;
   endtask

   task automatic send_vtx(input logic [31:0] x, input logic [31:0] y, input logic [11:0] c);
      logic [3:0][31:0] v;
      bit ok = 1'b0;
      v[0] = x; v[1] = y; v[2] = $urandom; v[3] = $urandom;
      vertex_in = v; color_in = c; valid_in = 1'b1; last_v = v;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_in);
         if (ready_out) begin ok = 1'b1; break; end
      end
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL accept_timeout: observed ready_out=0 expected ready_out=1 within 100 cycles");
      end
      model_accept(v, c);
      @(posedge clk_in); #1;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) begin @(posedge clk_in); #1; end
   endtask

   // Every output transfer must match the oldest expected triangle.
   always @(negedge clk_in) begin
      if (rst_in && valid_out && ready_in) begin
         tri_t e;
         xfer_t.push_back(cycle);
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_tri: observed %0h expected no transfer", {triangle_out, color_out});
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            assert ({triangle_out, color_out} === e) else begin
               fails++;
               $error("FAIL sb_tri: observed %0h expected %0h", {triangle_out, color_out}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tri_t             t1;
      logic [3:0][31:0] v4, v5;

      ready_in = 1'b1;
      #12;
      check("rst_valid", valid_out, 0);
      check("rst_tri_count", tri_count_out, 0);
      check("rst_cull_count", culled_count_out, 0);
      check("rst_triangle", triangle_out, 0);
      check("rst_color", color_out, 0);
      @(negedge clk_in); rst_in = 1'b1;
      @(posedge clk_in); #1;

      // basic assembly
      send_vtx(0, 0, 12'h111);
      send_vtx(10, 0, 12'h222);
      send_vtx(0, 10, 12'hF00);
      valid_in = 1'b0;
      check("basic_valid", valid_out, 1);
      check("basic_x2", triangle_out[2][0], 0);
      check("basic_y2", triangle_out[2][1], 10);
      check("basic_x1", triangle_out[1][0], 10);
      check("basic_color", color_out, 12'hF00);
      check("basic_tri_count", tri_count_out, 1);
      idle(2);

      // culling, with the non-culling instance fed the same three vertices
      nc_en = 1'b1;
      send_vtx(5, 5, 12'h123);
      send_vtx(5, 5, 12'h456);
      send_vtx(9, 1, 12'h789);
      valid_in = 1'b0;
      check("cull_valid", valid_out, 0);
      check("cull_count", culled_count_out, 1);
      check("cull_tri_count", tri_count_out, exp_tri);
      check("nc_valid", nc_valid_out, 1);
      check("nc_tri_count", nc_tri_count_out, 1);
      check("nc_cull_count", nc_culled_count_out, 0);
      check("nc_color", nc_color_out, 12'h789);
      nc_en = 1'b0;
      idle(2);

      // backpressure
      ready_in = 1'b0;
      send_vtx(1, 2, 12'h001);
      send_vtx(3, 4, 12'h002);
      send_vtx(5, 6, 12'h003);
      t1 = sb[0];
      send_vtx(7, 8, 12'h004);
      v4 = last_v;
      send_vtx(9, 10, 12'h005);
      v5 = last_v;
      vertex_in[0] = 32'd11; vertex_in[1] = 32'd12;
      vertex_in[2] = $urandom; vertex_in[3] = $urandom;
      color_in = 12'h006; valid_in = 1'b1;
      repeat (3) begin
         @(negedge clk_in);
         check("bp_ready_low", ready_out, 0);
         check("bp_valid_held", valid_out, 1);
         check("bp_tri_stable", triangle_out, t1.tri_v);
         check("bp_color_stable", color_out, t1.col);
      end
      @(posedge clk_in); #1;
      ready_in = 1'b1;
      @(negedge clk_in);
      check("bp_ready_release", ready_out, 1);
      model_accept(vertex_in, color_in);
      @(posedge clk_in); #1;
      ready_in = 1'b0; valid_in = 1'b0;
      check("bp_tri2_valid", valid_out, 1);
      check("bp_tri2_x2", triangle_out[2][0], 11);
      check("bp_tri2_v1", triangle_out[1], v5);
      check("bp_tri2_v0", triangle_out[0], v4);
      check("bp_tri2_color", color_out, 12'h006);
      idle(2);
      ready_in = 1'b1;
      idle(3);
      check("bp_tri_count", tri_count_out, exp_tri);

      // throughput
      xfer_t.delete();
      for (int j = 0; j < 30; j++) send_vtx(100 + j, 2 * j + 1, 12'(j));
      idle(3);
      check("tp_xfers", xfer_t.size(), 10);
      for (int k = 1; k < xfer_t.size(); k++) check("tp_spacing", xfer_t[k] - xfer_t[k-1], 3);
      check("tp_tri_count", tri_count_out, exp_tri);

      // reset mid-triangle
      send_vtx(7, 7, 12'hAAA);
      send_vtx(8, 9, 12'hBBB);
      valid_in = 1'b0;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      #2;
      check("mid_rst_valid", valid_out, 0);
      check("mid_rst_tri_count", tri_count_out, 0);
      check("mid_rst_cull_count", culled_count_out, 0);
      check("mid_rst_triangle", triangle_out, 0);
      check("mid_rst_color", color_out, 0);
      check("mid_rst_ready", ready_out, 1);
      @(negedge clk_in); rst_in = 1'b1;
      tb_slot = 0; exp_tri = '0; exp_cull = '0;
      @(posedge clk_in); #1;
      send_vtx(20, 30, 12'h0A0);
      send_vtx(40, 50, 12'h0B0);
      send_vtx(60, 70, 12'h0C0);
      valid_in = 1'b0;
      check("post_rst_valid", valid_out, 1);
      check("post_rst_v0x", triangle_out[0][0], 20);
      check("post_rst_tri_count", tri_count_out, 1);
      idle(2);

      // saturation
      @(negedge clk_in);
      force dut.tri_count = 16'hFFFE;
      #1;
      release dut.tri_count;
      exp_tri = 16'hFFFE;
      check("sat_preload", tri_count_out, 16'hFFFE);
      @(posedge clk_in); #1;
      send_vtx(1, 1, 12'h010);
      send_vtx(2, 1, 12'h020);
      send_vtx(1, 2, 12'h030);
      valid_in = 1'b0;
      check("sat_reach", tri_count_out, 16'hFFFF);
      send_vtx(3, 1, 12'h040);
      send_vtx(4, 1, 12'h050);
      send_vtx(3, 2, 12'h060);
      valid_in = 1'b0;
      check("sat_hold", tri_count_out, 16'hFFFF);
      check("sat_model", tri_count_out, exp_tri);
      idle(3);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 SHALL have parameter CULL_DEGENERATE, default 1: when 1, degenerate triangles are discarded rather than emitted.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in, input, 1 bit: upstream vertex valid (from the triangle vertex FIFO).
REQ-005 SHALL have port ready_out, output, 1 bit: this block accepts a vertex this cycle.
REQ-006 SHALL have port vertex_in, input, [3:0][31:0]: lane 0 = x, lane 1 = y, lane 2 = z, lane 3 = w.
REQ-007 SHALL have port color_in, input, 12 bits: per-vertex color, RGB444.
REQ-008 SHALL have port valid_out, output, 1 bit: a triangle is presented on triangle_out and color_out.
REQ-009 SHALL have port ready_in, input, 1 bit: downstream accepts the presented triangle.
REQ-010 SHALL have port triangle_out, output, [2:0][3:0][31:0]: index 0 = first vertex received, index 2 = last.
REQ-011 SHALL have port color_out, output, 12 bits: flat color of the triangle.
REQ-012 SHALL have port tri_count_out, output, 16 bits: number of triangles emitted.
REQ-013 SHALL have port culled_count_out, output, 16 bits: number of triangles culled.

Function
REQ-014 Vertex transfer SHALL occur when valid_in && ready_out; output transfer SHALL occur when valid_out && ready_in.
REQ-015 SHALL track a slot counter 0..2 giving the position of the next accepted vertex; each accepted vertex advances it, and 2 wraps to 0.
REQ-016 Accepted vertices in slots 0 and 1 SHALL be stored in internal registers v0 and v1; their colors are ignored.
REQ-017 ready_out SHALL be combinational: 1 when slot != 2, otherwise (!valid_out || ready_in).
REQ-018 On acceptance of a slot-2 vertex that is not culled:
  - triangle_out SHALL load {vertex_in, v1, v0} (index 2 = vertex_in);
  - color_out SHALL load color_in (last vertex is the provoking vertex);
  - valid_out SHALL be 1 on the following cycle.
  Acceptance-to-valid_out latency is 1 cycle.
REQ-019 Degenerate test SHALL apply when CULL_DEGENERATE=1: the triangle is degenerate if any pair of its three vertices has equal lane 0 AND equal lane 1 (exact 32-bit compare).
REQ-020 A culled triangle SHALL leave triangle_out and color_out unchanged and increment culled_count_out.
  - valid_out SHALL then fall to 0 if the held triangle transfers in the same cycle, and hold its value otherwise.
REQ-021 Without a new load, valid_out SHALL clear after an output transfer; triangle_out and color_out SHALL be stable while valid_out && !ready_in.
REQ-022 On a slot-2 acceptance in the same cycle as an output transfer, the new triangle SHALL replace the old one with valid_out staying 1, sustaining 1 triangle per 3 cycles with no bubble.
REQ-023 tri_count_out SHALL increment on each emitted (loaded) triangle, and culled_count_out on each culled one.
  - Both SHALL saturate at 16'hFFFF.
REQ-024 valid_in while ready_out=0 SHALL have no effect; the upstream block holds its data.

Reset
REQ-025 Assertion of rst_in (low), asynchronous and including mid-triangle, SHALL immediately set the outputs and state to:
  - valid_out=0, slot=0, tri_count_out=0, culled_count_out=0;
  - triangle_out=0, color_out=0, v0=0, v1=0.
  Any partial triangle is discarded.
REQ-026 After rst_in deasserts, the first accepted vertex SHALL occupy slot 0.

Verification
REQ-027 Basic assembly: with ready_in=1, send vertices with x,y = (0,0), (10,0), (0,10), colors 0x111, 0x222, 0xF00.
  - Required: valid_out=1 the cycle after the third vertex is accepted;
  - triangle_out[2].x=0 and triangle_out[2].y=10;
  - color_out=0xF00 and tri_count_out=1.
REQ-028 Culling: with CULL_DEGENERATE=1, send (5,5), (5,5), (9,1).
  - Required: valid_out stays 0 and culled_count_out=1.
  - With CULL_DEGENERATE=0, the same input yields valid_out=1 and tri_count_out=1.
REQ-029 Backpressure: hold ready_in=0 and send 6 valid vertices.
  - Required: the first triangle is held stable and ready_out=0 at slot 2 after 5 vertices are accepted.
  - Raising ready_in for 1 cycle transfers triangle 1 and accepts vertex 6 in that same cycle; triangle 2 is valid the next cycle.
REQ-030 Throughput: stream 30 non-degenerate vertices with valid_in=1 and ready_in=1.
  - Required: 10 output transfers, consecutive ones 3 cycles apart, and tri_count_out=10.
REQ-031 Reset mid-triangle: accept 2 vertices, pulse rst_in low, then send 3 new vertices.
  - Required: all outputs are 0 during reset, and the emitted triangle contains only the 3 post-reset vertices.
REQ-032 Saturation: force tri_count_out to 16'hFFFF (or emit 65536 triangles) and emit 1 more.
  - Required: tri_count_out remains 16'hFFFF.
